// File: rtl/encrypt_sequencer_pkg.sv
// Shared constants, state encoding and parameter-decoding helpers for the
// Program #1 encryption sequencer.
package encrypt_pkg;

  localparam logic [7:0] ADDR_PRE  = 8'd61;
  localparam logic [7:0] ADDR_PTN  = 8'd62;
  localparam logic [7:0] ADDR_SEED = 8'd63;
  localparam logic [7:0] PRE_MIN   = 8'd10;
  localparam logic [7:0] PRE_MAX   = 8'd15;
  localparam logic [7:0] SPACE     = 8'h20;

  localparam logic [6:0] TAP_TBL [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A,
                                         7'h69, 7'h5C, 7'h7E, 7'h7B};

  typedef enum logic [2:0] {IDLE, P0, P1, P2, P3, FETCH, WRITE, DONE} state_t;

  // Preamble length is held to the 10..15 window.
  function automatic logic [3:0] clamp_pre(input logic [7:0] v);
    logic [3:0] r;
    if (v < PRE_MIN)      r = PRE_MIN[3:0];
    else if (v > PRE_MAX) r = PRE_MAX[3:0];
    else                  r = v[3:0];
    return r;
  endfunction

  // Tap pattern selection: low nibble 8 picks the ninth entry, otherwise bits [2:0].
  function automatic logic [6:0] tap_sel(input logic [7:0] v);
    logic [3:0] sel;
    sel = (v[3:0] == 4'd8) ? 4'd8 : {1'b0, v[2:0]};
    return TAP_TBL[sel];
  endfunction

endpackage

// File: rtl/encrypt_sequencer_if.sv
// Data-memory master/slave bus used by the encryption sequencer.
interface encrypt_sequencer_if;
  logic [7:0] addr;
  logic       rd_en;
  logic       wr_en;
  logic [7:0] wdata;
  logic [7:0] rdata;

  modport master (output addr, rd_en, wr_en, wdata, input rdata);
  modport slave  (input addr, rd_en, wr_en, wdata, output rdata);
endinterface

// File: rtl/encrypt_sequencer_lfsr7_step.sv
// Combinational one-step advance of the 7-bit Fibonacci LFSR.
module lfsr7_step (
  input  logic [6:0] state,
  input  logic [6:0] taps,
  output logic [6:0] next
);
  assign next = {state[5:0], ^(state & taps)};
endmodule

// File: rtl/encrypt_sequencer.sv
// Program #1 encryption sequencer: reads parameters from data memory, walks
// the padded message, LFSR-encrypts each byte with even parity in bit 7 and
// writes the result to the output window.
module encrypt_sequencer
  import encrypt_pkg::*;
#(
  parameter int unsigned MSG_LEN  = 64,
  parameter int unsigned SRC_MAX  = 60,
  parameter int unsigned OUT_BASE = 64
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Start,
  output logic                Ack,
  encrypt_sequencer_if.master mem
);

  state_t     state, next_state;
  logic       start_q;
  logic [6:0] idx;
  logic [6:0] lfsr, taps, lfsr_next;
  logic [3:0] pre;

  logic [7:0] idx_w, off, src, cipher;
  logic [6:0] mixed;
  logic       in_range;

  logic [7:0] addr, wdata;
  logic       rd_en, wr_en;

  lfsr7_step u_step (.state(lfsr), .taps(taps), .next(lfsr_next));

  // Source window test; idx-pre is only meaningful once idx >= pre.
  assign idx_w    = {1'b0, idx};
  assign off      = idx_w - {4'b0, pre};
  assign in_range = (idx_w >= {4'b0, pre}) && (off <= 8'(SRC_MAX));

  // The WRITE cycle re-evaluates in_range with the same idx, so padding needs no flag.
  assign src    = in_range ? mem.rdata : SPACE;
  assign mixed  = src[6:0] ^ lfsr;
  assign cipher = {^mixed, mixed};

  // State, launch detect, parameter capture, counters and Ack register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      start_q <= 1'b1;
      Ack     <= 1'b0;
      idx     <= '0;
      lfsr    <= '0;
      taps    <= '0;
      pre     <= '0;
    end else begin
      state   <= next_state;
      start_q <= Start;
      Ack     <= (state == DONE) && !Start;
      case (state)
        P1: pre  <= clamp_pre(mem.rdata);
        P2: taps <= tap_sel(mem.rdata);
        P3: begin
          lfsr <= (mem.rdata[6:0] == 7'd0) ? 7'h01 : mem.rdata[6:0];
          idx  <= '0;
        end
        WRITE: begin
          lfsr <= lfsr_next;
          idx  <= idx + 7'd1;
        end
        default: ;
      endcase
    end
  end

  // Next-state and memory strobes/address/data decode.
  always_comb begin
    next_state = state;
    addr       = '0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    wdata      = '0;
    case (state)
      IDLE: if (!Start && start_q) next_state = P0;
      P0: begin
        addr = ADDR_PRE;  rd_en = 1'b1; next_state = P1;
      end
      P1: begin
        addr = ADDR_PTN;  rd_en = 1'b1; next_state = P2;
      end
      P2: begin
        addr = ADDR_SEED; rd_en = 1'b1; next_state = P3;
      end
      P3: next_state = FETCH;
      FETCH: begin
        if (in_range) begin
          addr  = off;
          rd_en = 1'b1;
        end
        next_state = WRITE;
      end
      WRITE: begin
        addr       = 8'(OUT_BASE) + idx_w;
        wr_en      = 1'b1;
        wdata      = cipher;
        next_state = (idx == 7'(MSG_LEN - 1)) ? DONE : FETCH;
      end
      DONE: if (Start) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign mem.addr  = addr;
  assign mem.rd_en = rd_en;
  assign mem.wr_en = wr_en;
  assign mem.wdata = wdata;

endmodule

// File: tb/tb_encrypt_sequencer.sv
// Directed bench for encrypt_sequencer with a data-memory model and golden encryptor.
module tb_encrypt_sequencer;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic Start = 1'b1;
  logic Ack;
  logic clear_req = 1'b0;

  encrypt_sequencer_if bus ();

  encrypt_sequencer dut (.Clk(Clk), .Reset(Reset), .Start(Start), .Ack(Ack), .mem(bus));

  always #5 Clk = ~Clk;

  logic [7:0] src_mem [0:255];
  logic [7:0] out_mem [0:63];
  logic [7:0] exp_out [0:63];
  int wr_cnt = 0;
  int bad_wr = 0;
  int clash  = 0;
  int total  = 0;
  int bad    = 0;

  // Memory model: 1-cycle read, writes land in the output window image.
  always @(posedge Clk) begin
    if (clear_req)
      for (int i = 0; i < 64; i++) out_mem[i] <= 8'hEE;
    if (bus.rd_en) bus.rdata <= src_mem[bus.addr];
    if (bus.wr_en) begin
      wr_cnt <= wr_cnt + 1;
      if (bus.addr < 8'd64 || bus.addr > 8'd127 || Ack) bad_wr <= bad_wr + 1;
      else out_mem[bus.addr[5:0]] <= bus.wdata;
    end
    if (bus.rd_en && bus.wr_en) clash <= clash + 1;
  end

  function automatic void golden(input logic [7:0] pre_raw, input logic [7:0] ptn,
                                 input logic [7:0] seed);
    int p;
    logic [6:0] tp, l;
    logic [7:0] s, c;
    p = (pre_raw < 10) ? 10 : (pre_raw > 15) ? 15 : int'(pre_raw);
    if (ptn[3:0] == 4'h8) tp = 7'h7B;
    else case (ptn[2:0])
      3'd0: tp = 7'h60; 3'd1: tp = 7'h48; 3'd2: tp = 7'h78; 3'd3: tp = 7'h72;
      3'd4: tp = 7'h6A; 3'd5: tp = 7'h69; 3'd6: tp = 7'h5C; default: tp = 7'h7E;
    endcase
    l = (seed[6:0] == 7'd0) ? 7'h01 : seed[6:0];
    for (int i = 0; i < 64; i++) begin
      s = (i >= p && (i - p) <= 60) ? src_mem[i - p] : 8'h20;
      c = s ^ {1'b0, l};
      c[7] = ^c[6:0];
      exp_out[i] = c;
      l = {l[5:0], ^(l & tp)};
    end
  endfunction

  task automatic load(input logic [7:0] pre_raw, input logic [7:0] ptn,
                      input logic [7:0] seed, input string text);
    for (int i = 0; i < 61; i++) src_mem[i] = (i < text.len()) ? 8'(text[i]) : 8'h20;
    src_mem[61] = pre_raw;
    src_mem[62] = ptn;
    src_mem[63] = seed;
    clear_req = 1'b1;
    @(posedge Clk); #1;
    clear_req = 1'b0;
  endtask

  // Start 1 -> 0; lat = edges from the launch edge to the one raising Ack (-1 on timeout).
  task automatic launch_wait(output int lat);
    Start = 1'b1;
    @(posedge Clk); @(posedge Clk); #1;
    Start = 1'b0;
    wait_ack(lat);
  endtask

  task automatic wait_ack(output int lat);
    lat = -1;
    for (int n = 0; n < 300; n++) begin
      @(posedge Clk); #1;
      if (Ack) begin lat = n; break; end
    end
  endtask

  task automatic check_out(input string name);
    for (int i = 0; i < 64; i++) begin
      total++;
      if (out_mem[i] !== exp_out[i]) begin
        bad++;
        $display("FAIL %s byte %0d: got %h want %h", name, 64 + i, out_mem[i], exp_out[i]);
      end
    end
  endtask

  task automatic check_lat(input string name, input int lat);
    total++;
    if (lat !== 133) begin
      bad++;
      $display("FAIL %s latency: got %0d want 133", name, lat);
    end
  endtask

  task automatic test_reset;
    Reset = 1'b0; Start = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    total++;
    if ({bus.addr, bus.rd_en, bus.wr_en, bus.wdata, Ack} !== 19'd0) begin
      bad++;
      $display("FAIL reset outputs: got %h want 0", {bus.addr, bus.rd_en, bus.wr_en, bus.wdata, Ack});
    end
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    total++;
    if ({bus.rd_en, bus.wr_en, Ack} !== 3'd0) begin
      bad++;
      $display("FAIL idle quiet: got %b want 000", {bus.rd_en, bus.wr_en, Ack});
    end
  endtask

  task automatic test_basic;
    int lat, w0;
    load(8'd12, 8'h00, 8'h01, "Mr. Watson, come here. I want to see you.");
    golden(8'd12, 8'h00, 8'h01);
    w0 = wr_cnt;
    launch_wait(lat);
    check_lat("t1", lat);
    check_out("t1");
    total++;
    if (wr_cnt - w0 !== 64) begin
      bad++;
      $display("FAIL t1 write count: got %0d want 64", wr_cnt - w0);
    end
  endtask

  task automatic test_pre_clamp_low;
    int lat;
    load(8'd3, 8'h00, 8'h01, "Mr. Watson, come here.");
    golden(8'd3, 8'h00, 8'h01);
    launch_wait(lat);
    check_lat("t2", lat);
    total++;
    if (out_mem[0] !== 8'h21) begin
      bad++;
      $display("FAIL t2 byte64: got %h want 21", out_mem[0]);
    end
    total++;
    if (out_mem[10] !== exp_out[10]) begin
      bad++;
      $display("FAIL t2 byte74: got %h want %h", out_mem[10], exp_out[10]);
    end
    check_out("t2");
  endtask

  task automatic test_taps;
    int lat;
    load(8'd200, 8'h08, 8'h01, "Hello there");
    golden(8'd200, 8'h08, 8'h01);
    launch_wait(lat);
    check_lat("t3a", lat);
    total++;
    if ({out_mem[0], out_mem[1], out_mem[2], out_mem[3]} !== 32'h21A3A62D) begin
      bad++;
      $display("FAIL t3 taps7B bytes64-67: got %h %h %h %h want 21 a3 a6 2d",
               out_mem[0], out_mem[1], out_mem[2], out_mem[3]);
    end
    check_out("t3a");
    load(8'd200, 8'h1A, 8'h01, "Hello there");
    golden(8'd200, 8'h1A, 8'h01);
    launch_wait(lat);
    total++;
    if ({out_mem[0], out_mem[1], out_mem[2], out_mem[3]} !== 32'h21222428) begin
      bad++;
      $display("FAIL t3 taps78 bytes64-67: got %h %h %h %h want 21 22 24 28",
               out_mem[0], out_mem[1], out_mem[2], out_mem[3]);
    end
    check_out("t3b");
  endtask

  task automatic test_zero_seed;
    int lat;
    load(8'd11, 8'h05, 8'h00, "Zero seed check");
    golden(8'd11, 8'h05, 8'h01);
    launch_wait(lat);
    check_lat("t4", lat);
    check_out("t4");
  endtask

  task automatic test_reset_midrun;
    int lat, w0;
    bit found;
    load(8'd13, 8'h03, 8'h5A, "Interrupted message");
    golden(8'd13, 8'h03, 8'h5A);
    Start = 1'b1;
    @(posedge Clk); @(posedge Clk); #1;
    Start = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(posedge Clk); #1;
      if (bus.wr_en && bus.addr == 8'd94) begin found = 1'b1; break; end
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL t5 reach idx30: got timeout want write at 94");
    end
    Reset = 1'b0;
    Start = 1'b1;
    #1;
    total++;
    if ({bus.addr, bus.rd_en, bus.wr_en, bus.wdata, Ack} !== 19'd0) begin
      bad++;
      $display("FAIL t5 async clear: got %h want 0", {bus.addr, bus.rd_en, bus.wr_en, bus.wdata, Ack});
    end
    w0 = wr_cnt;
    repeat (3) @(posedge Clk);
    #1;
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    total++;
    if (wr_cnt !== w0) begin
      bad++;
      $display("FAIL t5 writes after reset: got %0d want 0", wr_cnt - w0);
    end
    load(8'd13, 8'h03, 8'h5A, "Interrupted message");
    launch_wait(lat);
    check_lat("t5", lat);
    check_out("t5");
  endtask

  task automatic test_back_to_back;
    int lat, w0;
    load(8'd14, 8'h06, 8'h33, "First of two");
    golden(8'd14, 8'h06, 8'h33);
    launch_wait(lat);
    check_out("t6a");
    Start = 1'b1;
    @(posedge Clk); #1;
    total++;
    if (Ack !== 1'b0) begin
      bad++;
      $display("FAIL t6 ack drop: got %b want 0", Ack);
    end
    src_mem[63] = 8'h47;
    golden(8'd14, 8'h06, 8'h47);
    w0 = wr_cnt;
    @(posedge Clk); #1;
    Start = 1'b0;
    wait_ack(lat);
    check_lat("t6b", lat);
    check_out("t6b");
    total++;
    if (wr_cnt - w0 !== 64) begin
      bad++;
      $display("FAIL t6 write count: got %0d want 64", wr_cnt - w0);
    end
    repeat (3) @(posedge Clk);
    #1;
    total++;
    if (bad_wr !== 0 || clash !== 0) begin
      bad++;
      $display("FAIL bus rules: got bad_wr=%0d clash=%0d want 0 0", bad_wr, clash);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pre_clamp_low();
    test_taps();
    test_zero_seed();
    test_reset_midrun();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
